// File: rtl/mac_dot_if.sv
// Command, operand and result handshakes for the dot-product sequencer.
interface mac_dot_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic             op_valid;
  logic             op_ready;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic             res_ovf;
  logic             busy;

  modport master (
    output cmd_valid, cmd_len, abort,
    output op_valid, op_a, op_b, res_ready,
    input  cmd_ready, op_ready, res_valid,
    input  res_data, res_ovf, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, abort,
    input  op_valid, op_a, op_b, res_ready,
    output cmd_ready, op_ready, res_valid,
    output res_data, res_ovf, busy
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: multiply register stage, then a 32-bit
// accumulate stage with a sticky carry-out flag.
module mac_dot_sequencer #(
  parameter int LEN_W = 8
) (
  input logic     clk,
  input logic     rst,
  mac_dot_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [31:0]      p_reg;
  logic             p_vld;
  logic [31:0]      acc;
  logic             ovf;
  logic [32:0]      sum;

  assign sum = {1'b0, acc} + {1'b0, p_reg};

  assign bus.cmd_ready = (state == IDLE);
  assign bus.op_ready  = (state == RUN);
  assign bus.res_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.res_data  = acc;
  assign bus.res_ovf   = ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      p_reg <= '0;
      p_vld <= 1'b0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      // stage 2 runs in every state; a new command overrides it below
      if (p_vld) begin
        acc <= sum[31:0];
        ovf <= ovf | sum[32];
      end
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            acc <= '0;
            ovf <= 1'b0;
            if (bus.cmd_len != '0) begin
              p_vld <= 1'b0;
              cnt   <= bus.cmd_len;
              state <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            p_vld <= 1'b0;
            state <= IDLE;
          end else if (bus.op_valid) begin
            p_reg <= 32'(bus.op_a) * 32'(bus.op_b);
            p_vld <= 1'b1;
            cnt   <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) state <= DRAIN;
          end else begin
            p_vld <= 1'b0;
          end
        end
        DRAIN: begin
          p_vld <= 1'b0;
          state <= bus.abort ? IDLE : DONE;
        end
        DONE: begin
          if (bus.abort || bus.res_ready) begin
            p_vld <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
